// File: rtl/infoframe_pkg.sv
// ============================================================================
// Module      : infoframe_pkg
// Description : Shared types, type codes and header helper for InfoFrame
//               packet sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package infoframe_pkg;

  localparam logic [6:0] IF_TYPE_AVI    = 7'd2;
  localparam logic [6:0] IF_TYPE_SPD    = 7'd3;
  localparam logic [6:0] IF_TYPE_AUDIO  = 7'd4;
  localparam int         IF_MAX_PAYLOAD = 27;

  // Header bytes packed as {HB2, HB1, HB0}
  typedef logic [23:0] if_header_t;

  // Four 56-bit subpackets; byte k of the packet sits at flat bits [8k+7:8k]
  typedef logic [3:0][55:0] if_sub_t;

  // PB0 (checksum) through PB27, same bit layout as if_sub_t
  typedef logic [IF_MAX_PAYLOAD:0][7:0] if_bytes_t;

  function automatic if_header_t infoframe_header(
    input logic [6:0] if_type,
    input logic [7:0] if_version,
    input logic [4:0] if_length
  );
    return {3'b000, if_length, if_version, 1'b1, if_type};
  endfunction

endpackage

`default_nettype wire

// File: rtl/infoframe_checksum_acc.sv
// ============================================================================
// Module      : infoframe_checksum_acc
// Description : Serial 8-bit mod-256 accumulator. Load seeds the sum, add
//               accumulates one byte per cycle, checksum is the two's
//               complement that brings the total to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module infoframe_checksum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       add,
  input  logic [7:0] add_val,
  output logic [7:0] checksum
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // Next accumulator value: load has priority over add
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = load_val;
    end else if (add) begin
      acc_d = acc_q + add_val;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign checksum = 8'd0 - acc_q;

endmodule

`default_nettype wire

// File: rtl/infoframe_builder.sv
// ============================================================================
// Module      : infoframe_builder
// Description : Runtime-programmable InfoFrame source. Host writes payload
//               bytes into a staging buffer and commits; the checksum is
//               built serially and the packet is double-buffered into an
//               output bank offered to the packet picker via valid/ack.
//               Optional macro INFOFRAME_REPEAT_EN keeps packet_valid high
//               after the first packet so it is resent every frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module infoframe_builder
  import infoframe_pkg::*;
#(
  parameter logic [6:0] IF_TYPE    = 7'd4,
  parameter logic [7:0] IF_VERSION = 8'd1,
  parameter logic [4:0] IF_LENGTH  = 5'd10
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       busy,
  output if_header_t header,
  output if_sub_t    sub,
  output logic       packet_valid,
  input  logic       packet_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam if_header_t HEADER     = infoframe_header(IF_TYPE, IF_VERSION, IF_LENGTH);
  localparam logic [7:0] HEADER_SUM = HEADER[7:0] + HEADER[15:8] + HEADER[23:16];

  if (IF_LENGTH < 5'd1 || IF_LENGTH > 5'd27) begin : g_len_check
    $error("infoframe_builder: IF_LENGTH must be in 1..27");
  end

  state_t     state_q,   state_d;
  logic [4:0] idx_q,     idx_d;
  if_bytes_t  staging_q, staging_d;
  if_bytes_t  bank_q,    bank_d;
  logic       valid_q,   valid_d;

  logic       acc_load;
  logic       acc_add;
  logic [7:0] acc_add_val;
  logic [7:0] acc_checksum;
  logic       wr_ok;

  infoframe_checksum_acc u_acc (
    .clk      (clk_pixel),
    .rst      (reset),
    .load     (acc_load),
    .load_val (HEADER_SUM),
    .add      (acc_add),
    .add_val  (acc_add_val),
    .checksum (acc_checksum)
  );

  // Staging writes, checksum sequencing and output-bank swap
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    staging_d   = staging_q;
    bank_d      = bank_q;
    valid_d     = valid_q;
    acc_load    = 1'b0;
    acc_add     = 1'b0;
    acc_add_val = 8'h00;

    // Staging only accepts in-range writes while idle, so it is frozen
    // throughout CALC/PEND and the swap copies exactly what was summed.
    wr_ok = wr_en && (state_q == ST_IDLE) && (wr_addr != 5'd0) && (wr_addr <= IF_LENGTH);
    if (wr_ok) begin
      staging_d[wr_addr] = wr_data;
    end

`ifndef INFOFRAME_REPEAT_EN
    // One transmission per commit: an ack consumes the packet
    if (packet_ack && valid_q) begin
      valid_d = 1'b0;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          acc_load = 1'b1;
          idx_d    = 5'd1;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_add     = 1'b1;
        acc_add_val = staging_q[idx_q];
        if (idx_q == IF_LENGTH) begin
          state_d = ST_PEND;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_PEND: begin
        // Swap only when the picker is not mid-way through the old packet
        if (!valid_q || packet_ack) begin
          for (int k = 1; k <= IF_MAX_PAYLOAD; k++) begin
            bank_d[k] = (k <= int'(IF_LENGTH)) ? staging_q[k] : 8'h00;
          end
          bank_d[0] = acc_checksum;
          valid_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 5'd0;
      staging_q <= '0;
      bank_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      bank_q    <= bank_d;
      valid_q   <= valid_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign header       = HEADER;
  assign sub          = bank_q;
  assign packet_valid = valid_q;

endmodule

`default_nettype wire

// File: doc/infoframe_builder.md
Name: infoframe_builder

Overview:
- Runtime-programmable HDMI/CEA-861 InfoFrame packet source; successor to the fixed-field audio InfoFrame constant block.
- Host logic writes payload bytes PB1..PBn into a staging buffer, then commits. The block computes the checksum serially and double-buffers the result.
- It presents a stable header plus 4×56-bit subpackets to the data-island packet picker under a valid/ack handshake.
- One instance per InfoFrame type (audio, AVI, SPD, ...), selected by parameters.

Parameters:
- IF_TYPE, 7'd4, InfoFrame type code. Header byte0 = {1'b1, IF_TYPE}.
- IF_VERSION, 8'd1, InfoFrame version byte.
- IF_LENGTH, 5'd10, payload length n. Legal range 1..27; elaboration error outside this range.

Ports:
- clk_pixel  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  staging write strobe.
- wr_addr  in  5  payload byte index. 1..IF_LENGTH valid.
- wr_data  in  8  payload byte value.
- commit  in  1  single-cycle request to build a packet from the staging buffer.
- busy  out  1  high in CALC/PEND; writes and commit are ignored while high.
- header  out  24  {{3'b0,IF_LENGTH}, IF_VERSION, {1'b1,IF_TYPE}}. Constant.
- sub  out  56×[3:0]  output bank. sub[i] = {PB(7i+6) … PB(7i)}, PB0 = checksum.
- packet_valid  out  1  output bank holds a committed packet.
- packet_ack  in  1  single-cycle pulse from the picker: packet consumed.

Behaviour:
- Reset (synchronous, any state, mid-CALC included):
  - staging and output bank = 0; packet_valid = 0; busy = 0; accumulator = 0; FSM = IDLE.
- Staging writes:
  - Accepted only when wr_en && !busy && 1 ≤ wr_addr ≤ IF_LENGTH.
  - All other writes (address 0, address > IF_LENGTH, or while busy) are silently dropped.
  - Write and commit in the same IDLE cycle: the write lands first and is included in the packet.
- FSM states: IDLE, CALC, PEND.
  - IDLE → CALC on commit. Accumulator loads the header byte sum (mod 256), idx = 1.
  - CALC: one cycle per byte; acc += staging[idx], idx++. After IF_LENGTH cycles → PEND.
  - PEND: swap when (!packet_valid || packet_ack).
    - Output bank ← staging; PB0 ← 8'd0 - acc (mod 256); bytes above IF_LENGTH forced to 0.
    - packet_valid ← 1; → IDLE.
  - Without blocking: commit sampled at cycle 0 → packet_valid/new sub visible at cycle IF_LENGTH+2.
  - A commit while busy is dropped. No queueing.
- Handshake:
  - sub is stable while packet_valid is high, except in the cycle after a PEND swap.
  - packet_ack while packet_valid = 0 is ignored.
  - packet_ack with no swap: packet_valid → 0 next cycle (subject to the optional feature).
  - packet_ack coincident with a swap: the swap wins; packet_valid stays 1 with the new content.
- Staging writes made after commit (while IDLE again) never alter the output bank until the next commit.

Optional Feature:
- Macro: INFOFRAME_REPEAT_EN.
- Defined: packet_valid, once set, stays high until reset. packet_ack only marks a transmission point, which is a legal swap point. This matches HDMI's once-per-frame InfoFrame resend without host involvement.
- Undefined: behaviour as above; one transmission per commit.

Decomposition:
- Package infoframe_pkg:
  - constants IF_TYPE_AVI = 7'd2, IF_TYPE_SPD = 7'd3, IF_TYPE_AUDIO = 7'd4, IF_MAX_PAYLOAD = 27;
  - typedef for the 24-bit header;
  - typedef for the 4×56 subpacket array;
  - function infoframe_header(type, version, length).
- Sub-module infoframe_checksum_acc: serial 8-bit mod-256 accumulator with load/add/negate. It is reused by other InfoFrame sources.

Test Plan:
- Audio defaults (4/1/10): write PB1 = 0x01, commit at cycle 0 → packet_valid rises at cycle 12; header = 0x0A0184; PB0 = 0x70; all other PB = 0.
- Invalid writes: wr_addr = 0, 11, 31 with data 0xFF, then commit → output bytes unchanged from staging contents; checksum consistent (sum of all 31 bytes ≡ 0 mod 256).
- Blocked swap: packet_valid = 1, recommit with PB4 = 0x13 and no ack → stays in PEND with busy = 1, old sub held. Ack pulse → new sub next cycle; packet_valid stays 1.
- Busy drops: commit, then wr_en / commit during CALC cycles 3–5 → ignored. Result equals the pre-commit staging contents.
- Reset mid-CALC (cycle 4) → next cycle packet_valid = 0, busy = 0, sub = 0. A subsequent commit works normally.
- INFOFRAME_REPEAT_EN on/off: 3 ack pulses after one commit → valid stays 1 throughout (defined) vs drops after the first ack (undefined).
